life_pattern_loader: RTL and testbench

Upstream loader for life_array_4x4. Accepts a 16-bit seed pattern over a valid/ready handshake and writes all 16 cells into the array one per cycle on row/col/val/write_enb. It then reads back alive to confirm the load and gates the array's run input so the array does not evolve while loading.

---
 rtl/life_pattern_loader.sv | 145 ++++++++++++++
 tb/tb_life_pattern_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/life_pattern_loader.sv
// Loads a 16-cell seed into life_array_4x4 one cell per cycle, verifies it
// through the alive readback and keeps the array frozen while doing so.
module life_pattern_loader #(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ROWS*COLS-1:0]      pattern,
  input  logic                      pattern_valid,
  output logic                      pattern_ready,
  input  logic                      run_req,
  input  logic [ROWS*COLS-1:0]      alive,
  output logic [$clog2(ROWS)-1:0]   row,
  output logic [$clog2(COLS)-1:0]   col,
  output logic                      val,
  output logic                      write_enb,
  output logic                      run,
  output logic                      busy,
  output logic                      done,
  output logic                      load_error
);

  localparam int CELLS = ROWS * COLS;
  localparam int IW    = $clog2(CELLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int SW    = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE,
    CHECK
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      next_idx;
  logic [SW-1:0]      settle_q, settle_d;
  logic [CELLS-1:0]   pat_q, pat_d;
  logic [RW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic               val_q, val_d;
  logic               we_q, we_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // idx_q is the cell currently presented on row/col/val; the accept edge
  // already presents cell 0 so the array sees a write in the very next cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    pat_d    = pat_q;
    row_d    = row_q;
    col_d    = col_q;
    val_d    = val_q;
    we_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    next_idx = idx_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (pattern_valid) begin
          state_d = LOAD;
          pat_d   = pattern;
          idx_d   = '0;
          err_d   = 1'b0;
          we_d    = 1'b1;
          row_d   = '0;
          col_d   = '0;
          val_d   = pattern[0];
        end
      end
      LOAD: begin
        if (idx_q == IW'(CELLS - 1)) begin
          state_d  = SETTLE;
          settle_d = '0;
        end else begin
          idx_d = next_idx;
          we_d  = 1'b1;
          row_d = RW'(next_idx / COLS);
          col_d = CW'(next_idx % COLS);
          val_d = pat_q[next_idx];
        end
      end
      SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      CHECK: begin
        done_d  = 1'b1;
        err_d   = (alive != pat_q);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      pat_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      val_q    <= 1'b0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      pat_q    <= pat_d;
      row_q    <= row_d;
      col_q    <= col_d;
      val_q    <= val_d;
      we_q     <= we_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // run is also gated by reset so the array cannot evolve while the loader is held.
  assign pattern_ready = (state_q == IDLE);
  assign busy          = ~pattern_ready;
  assign run           = run_req & pattern_ready & reset;
  assign row           = row_q;
  assign col           = col_q;
  assign val           = val_q;
  assign write_enb     = we_q;
  assign done          = done_q;
  assign load_error    = err_q;

endmodule

// File: tb/tb_life_pattern_loader.sv
// Self-checking bench for life_pattern_loader with a behavioural 4x4 life array.
module tb_life_pattern_loader;

  localparam int S        = 1;
  localparam int BUSY_CYC = 17 + S;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pattern;
  logic        pattern_valid;
  logic        pattern_ready;
  logic        run_req;
  logic [15:0] alive;
  logic [1:0]  row;
  logic [1:0]  col;
  logic        val;
  logic        write_enb;
  logic        run;
  logic        busy;
  logic        done;
  logic        load_error;

  logic [15:0] arr = '0;
  logic        force_en;
  logic [15:0] force_val;
  int          total;
  int          bad;
  bit          exp_err_sticky;

  typedef struct {
    logic [15:0] pat;
    bit          frc;
    logic [15:0] fval;
    bit          rreq;
    bit          exp_err;
    logic [15:0] exp_next;
  } vec_t;

  vec_t tbl[7];

  life_pattern_loader #(.ROWS(4), .COLS(4), .SETTLE_CYCLES(S)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .pattern       (pattern),
    .pattern_valid (pattern_valid),
    .pattern_ready (pattern_ready),
    .run_req       (run_req),
    .alive         (alive),
    .row           (row),
    .col           (col),
    .val           (val),
    .write_enb     (write_enb),
    .run           (run),
    .busy          (busy),
    .done          (done),
    .load_error    (load_error)
  );

  always #5 clk = ~clk;

  assign alive = force_en ? force_val : arr;

  // Conway generation on a bounded 4x4 grid (cells outside the grid are dead).
  function automatic logic [15:0] life_gen(input logic [15:0] g);
    logic [15:0] n;
    n = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 4 && c + dc >= 0 && c + dc < 4)
              cnt += int'(g[(r + dr) * 4 + c + dc]);
          end
        end
        n[r * 4 + c] = (cnt == 3) || (g[r * 4 + c] && cnt == 2);
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (write_enb) arr[int'(row) * 4 + int'(col)] <= val;
    else if (run)  arr <= life_gen(arr);
  end

  function automatic logic [10:0] out_vec();
    return {write_enb, row, col, val, busy, pattern_ready, done, run, load_error};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge with the loader idle; ends at a falling edge, idle again.
  task automatic apply_stimulus(input logic [15:0] pat, input bit frc, input logic [15:0] fval,
                                input bit rreq, input bit exp_err, input logic [15:0] exp_next);
    int          guard;
    int          kk;
    logic [10:0] exp_v;
    pattern       = pat;
    pattern_valid = 1'b1;
    run_req       = rreq;
    force_en      = frc;
    force_val     = fval;
    guard         = 0;
    while (pattern_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check_output("ready_timeout", pattern_ready, 1);
    #1;
    check_output("idle_err_sticky", load_error, exp_err_sticky);
    check_output("idle_run", run, rreq);
    @(negedge clk);
    pattern       = 16'($urandom);
    pattern_valid = 1'b0;
    for (int k = 0; k <= BUSY_CYC; k++) begin
      kk    = (k < 16) ? k : 15;
      exp_v = {k < 16, 2'(kk / 4), 2'(kk % 4), pat[kk], k < BUSY_CYC, !(k < BUSY_CYC),
               k == BUSY_CYC, rreq && (k >= BUSY_CYC), (k == BUSY_CYC) ? exp_err : 1'b0};
      check_output($sformatf("load pat=%h k=%0d", pat, k), out_vec(), exp_v);
      if (k == BUSY_CYC && !frc) check_output("alive_at_done", alive, pat);
      if (k < BUSY_CYC) @(negedge clk);
    end
    @(negedge clk);
    check_output("err_after_done", load_error, exp_err);
    check_output("done_one_cycle", done, 0);
    check_output("array_next", arr, exp_next);
    exp_err_sticky = exp_err;
    run_req        = 1'b0;
    force_en       = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] fv;
    bit          frc;
    bit          rreq;
    int          nready;
    int          nwe0;
    int          guard;

    tbl[0] = '{16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001};
    tbl[1] = '{16'h6186, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h2664};
    tbl[2] = '{16'h00F0, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h00F0};
    tbl[3] = '{16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFFFF};
    tbl[4] = '{16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[5] = '{16'h8000, 1'b1, 16'h8000, 1'b0, 1'b0, 16'h8000};
    tbl[6] = '{16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};

    total          = 0;
    bad            = 0;
    exp_err_sticky = 1'b0;
    rst_n          = 1'b0;
    pattern        = '0;
    pattern_valid  = 1'b0;
    run_req        = 1'b0;
    force_en       = 1'b0;
    force_val      = '0;

    #12;
    check_output("reset_state", out_vec(), {1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("ready_after_reset", {pattern_ready, busy}, 2'b10);

    $display("[TB] directed table");
    for (int i = 0; i < 7; i++)
      apply_stimulus(tbl[i].pat, tbl[i].frc, tbl[i].fval, tbl[i].rreq, tbl[i].exp_err, tbl[i].exp_next);

    $display("[TB] random patterns against model");
    for (int i = 0; i < 8; i++) begin
      a    = 16'($urandom);
      frc  = ($urandom_range(0, 2) == 0);
      fv   = ($urandom_range(0, 1) == 0) ? a : (a ^ (16'h1 << $urandom_range(0, 15)));
      rreq = 1'($urandom_range(0, 1));
      apply_stimulus(a, frc, fv, rreq, frc && (fv != a), rreq ? life_gen(a) : a);
    end

    $display("[TB] back-to-back loads");
    a             = 16'hC3A5;
    b             = 16'h5A3C;
    pattern       = a;
    pattern_valid = 1'b1;
    @(negedge clk);
    pattern = b;
    nready  = 0;
    nwe0    = 0;
    for (int k = 0; k <= BUSY_CYC + 1; k++) begin
      if (k <= BUSY_CYC && !pattern_ready) nready++;
      if (!write_enb) nwe0++;
      if (k == BUSY_CYC) begin
        check_output("b2b_first_done", done, 1);
        check_output("b2b_first_alive", alive, a);
      end
      if (k == BUSY_CYC + 1)
        check_output("b2b_second_start", {write_enb, row, col, val, busy}, {1'b1, 2'd0, 2'd0, b[0], 1'b1});
      if (k < BUSY_CYC + 1) @(negedge clk);
    end
    pattern_valid = 1'b0;
    check_output("b2b_ready_low_cycles", nready, BUSY_CYC);
    check_output("b2b_write_gap", nwe0, S + 2);
    guard = 0;
    while (done !== 1'b1 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check_output("b2b_second_done", done, 1);
    check_output("b2b_second_alive", arr, b);
    check_output("b2b_second_err", load_error, 0);
    @(negedge clk);

    $display("[TB] reset in the middle of a load");
    pattern       = 16'hA5C3;
    pattern_valid = 1'b1;
    run_req       = 1'b1;
    @(negedge clk);
    pattern_valid = 1'b0;
    repeat (7) @(negedge clk);
    check_output("pre_reset_idx7", {write_enb, row, col, busy}, {1'b1, 2'd1, 2'd3, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    check_output("reset_async_drop", {write_enb, busy, run, done, load_error}, 5'b0);
    @(negedge clk);
    rst_n   = 1'b1;
    run_req = 1'b0;
    #1;
    check_output("post_reset_idle", {pattern_ready, busy, write_enb}, 3'b100);
    exp_err_sticky = 1'b0;
    apply_stimulus(16'h3C5A, 1'b0, 16'h0000, 1'b1, 1'b0, life_gen(16'h3C5A));

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
